// File: rtl/counter_mode_sequencer.sv
// rtl/counter_mode_sequencer.sv - mode/enable sequencer driving a universal up/down counter
// Walks UP -> DOWN -> UPDOWN -> HOLD with latched dwell lengths, optional looping.
module counter_mode_sequencer #(
  parameter int DWELL_W  = 8,
  parameter int HOLD_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               loop,
  input  logic [DWELL_W-1:0] dwell_up,
  input  logic [DWELL_W-1:0] dwell_down,
  input  logic [DWELL_W-1:0] dwell_ud,
  output logic               enable,
  output logic [1:0]         mode,
  output logic [2:0]         phase,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UP     = 3'd1,
    S_DOWN   = 3'd2,
    S_UPDOWN = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);

  state_t             r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [7:0]         r_hold_cnt;
  logic [DWELL_W-1:0] r_up;
  logic [DWELL_W-1:0] r_down;
  logic [DWELL_W-1:0] r_ud;
  logic               r_loop;
  logic               r_enable;
  logic [1:0]         r_mode;
  logic               r_busy;
  logic               r_done;

  state_t             w_next;
  state_t             w_first;
  state_t             w_after_up;
  state_t             w_after_down;
  logic [DWELL_W-1:0] w_src_up;
  logic [DWELL_W-1:0] w_src_down;
  logic [DWELL_W-1:0] w_src_ud;
  logic [DWELL_W-1:0] w_cnt_next;
  logic [7:0]         w_hold_next;
  logic               w_latch;
  logic               w_enter;
  logic               w_enable;
  logic [1:0]         w_mode;
  logic               w_busy;
  logic               w_done;

  // Dwell values come straight from the inputs on the accepting edge, otherwise from the latch.
  always_comb begin
    w_src_up   = (r_state == S_IDLE) ? dwell_up   : r_up;
    w_src_down = (r_state == S_IDLE) ? dwell_down : r_down;
    w_src_ud   = (r_state == S_IDLE) ? dwell_ud   : r_ud;

    if (w_src_up != '0)        w_first = S_UP;
    else if (w_src_down != '0) w_first = S_DOWN;
    else if (w_src_ud != '0)   w_first = S_UPDOWN;
    else                       w_first = S_HOLD;

    if (w_src_down != '0)      w_after_up = S_DOWN;
    else if (w_src_ud != '0)   w_after_up = S_UPDOWN;
    else                       w_after_up = S_HOLD;

    if (w_src_ud != '0)        w_after_down = S_UPDOWN;
    else                       w_after_down = S_HOLD;
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_hold_next = r_hold_cnt;
    w_latch     = 1'b0;
    w_enter     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch = 1'b1;
          w_enter = 1'b1;
          w_next  = w_first;
        end
      end
      S_UP: begin
        if (r_cnt == '0) begin
          w_enter = 1'b1;
          w_next  = w_after_up;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_DOWN: begin
        if (r_cnt == '0) begin
          w_enter = 1'b1;
          w_next  = w_after_down;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_UPDOWN: begin
        if (r_cnt == '0) begin
          w_enter = 1'b1;
          w_next  = S_HOLD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == 8'd0) begin
          w_enter = 1'b1;
          w_next  = r_loop ? w_first : S_DONE;
        end else begin
          w_hold_next = r_hold_cnt - 8'd1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    if (abort) begin
      w_next  = S_IDLE;
      w_latch = 1'b0;
      w_enter = 1'b0;
    end

    // Counters hold "cycles remaining minus one" so a phase ends when they read zero.
    if (w_enter) begin
      case (w_next)
        S_UP:     w_cnt_next  = w_src_up - 1'b1;
        S_DOWN:   w_cnt_next  = w_src_down - 1'b1;
        S_UPDOWN: w_cnt_next  = w_src_ud - 1'b1;
        S_HOLD:   w_hold_next = HOLD_LOAD;
        default:  w_cnt_next  = r_cnt;
      endcase
    end
  end

  always_comb begin
    w_enable = 1'b0;
    w_mode   = 2'b00;
    w_busy   = (w_next != S_IDLE);
    w_done   = (w_next == S_DONE);
    case (w_next)
      S_UP:     begin w_enable = 1'b1; w_mode = 2'b01; end
      S_DOWN:   begin w_enable = 1'b1; w_mode = 2'b10; end
      S_UPDOWN: begin w_enable = 1'b1; w_mode = 2'b11; end
      default:  begin w_enable = 1'b0; w_mode = 2'b00; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hold_cnt <= 8'd0;
      r_up       <= '0;
      r_down     <= '0;
      r_ud       <= '0;
      r_loop     <= 1'b0;
      r_enable   <= 1'b0;
      r_mode     <= 2'b00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_hold_cnt <= w_hold_next;
      r_enable   <= w_enable;
      r_mode     <= w_mode;
      r_busy     <= w_busy;
      r_done     <= w_done;
      if (w_latch) begin
        r_up   <= dwell_up;
        r_down <= dwell_down;
        r_ud   <= dwell_ud;
        r_loop <= loop;
      end
    end
  end

  assign enable = r_enable;
  assign mode   = r_mode;
  assign phase  = r_state;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_counter_mode_sequencer.sv
// tb/tb_counter_mode_sequencer.sv - directed vector bench for counter_mode_sequencer
module tb_counter_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       loop;
  logic [7:0] du;
  logic [7:0] dd;
  logic [7:0] dud;
  logic       enable;
  logic [1:0] mode;
  logic [2:0] phase;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [7:0] du;
    logic [7:0] dd;
    logic [7:0] dud;
    int         done_cyc;
  } vec_t;

  vec_t vecs[7];

  counter_mode_sequencer #(.DWELL_W(8), .HOLD_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
    .dwell_up(du), .dwell_down(dd), .dwell_ud(dud),
    .enable(enable), .mode(mode), .phase(phase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {enable, mode, busy, done} expected for each phase code
  function automatic logic [4:0] exp_out(int ph);
    case (ph)
      1:       return 5'b1_01_1_0;
      2:       return 5'b1_10_1_0;
      3:       return 5'b1_11_1_0;
      4:       return 5'b0_00_1_0;
      5:       return 5'b0_00_1_1;
      default: return 5'b0_00_0_0;
    endcase
  endfunction

  task automatic check_phase(string name, int cyc, int exp_ph);
    logic [4:0] e;
    logic [2:0] p;
    e = exp_out(exp_ph);
    p = 3'(exp_ph);
    checks++;
    if ({enable, mode, busy, done} !== e || phase !== p) begin
      errors++;
      $display("FAIL %s cyc %0d: got en=%0b mode=%0b phase=%0d busy=%0b done=%0b, want en=%0b mode=%0b phase=%0d busy=%0b done=%0b",
               name, cyc, enable, mode, phase, busy, done, e[4], e[3:2], p, e[1], e[0]);
    end
  endtask

  task automatic build_seq(int u, int d, int ud, bit lp);
    for (int i = 0; i < u; i++)  exp_q.push_back(1);
    for (int i = 0; i < d; i++)  exp_q.push_back(2);
    for (int i = 0; i < ud; i++) exp_q.push_back(3);
    for (int i = 0; i < 4; i++)  exp_q.push_back(4);
    if (!lp) begin
      exp_q.push_back(5);
      exp_q.push_back(0);
    end
  endtask

  // Drives one start (held start_cyc edges) and checks every cycle against exp_q.
  task automatic run(string name, logic [7:0] u, logic [7:0] d, logic [7:0] ud, logic lp,
                     int start_cyc, int done_cyc);
    int first_done;
    first_done = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        du = u; dd = d; dud = ud; loop = lp;
      end else if (i == 1 && start_cyc == 1) begin
        du = 8'($urandom); dd = 8'($urandom); dud = 8'($urandom); loop = ~lp;
      end
      start = (i < start_cyc);
      @(posedge clk);
      #1;
      check_phase(name, i + 1, exp_q[i]);
      if (done && first_done < 0) first_done = i + 1;
    end
    @(negedge clk);
    start = 1'b0;
    if (done_cyc > 0) begin
      checks++;
      if (first_done != done_cyc) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d, want %0d", name, first_done, done_cyc);
      end
    end
  endtask

  task automatic do_abort(string name);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check_phase(name, 0, 0);
    @(negedge clk);
    abort = 1'b0;
    @(posedge clk);
    #1;
    check_phase(name, 1, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
    du = 8'd0; dd = 8'd0; dud = 8'd0;
    vecs[0] = '{8'd3,   8'd2, 8'd1, 11};
    vecs[1] = '{8'd0,   8'd5, 8'd0, 10};
    vecs[2] = '{8'd0,   8'd0, 8'd0, 5};
    vecs[3] = '{8'd1,   8'd0, 8'd0, 6};
    vecs[4] = '{8'd0,   8'd0, 8'd7, 12};
    vecs[5] = '{8'd255, 8'd0, 8'd1, 261};
    vecs[6] = '{8'd2,   8'd0, 8'd3, 10};

    #2;
    check_phase("reset", 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      exp_q.delete();
      build_seq(int'(vecs[v].du), int'(vecs[v].dd), int'(vecs[v].dud), 1'b0);
      run($sformatf("vec%0d", v), vecs[v].du, vecs[v].dd, vecs[v].dud, 1'b0, 1, vecs[v].done_cyc);
    end

    // start held 10 cycles: second acceptance only after DONE -> IDLE
    exp_q.delete();
    build_seq(1, 1, 1, 1'b0);
    build_seq(1, 1, 1, 1'b0);
    run("start_held", 8'd1, 8'd1, 8'd1, 1'b0, 10, 8);

    // looping 2/2/2, abort in second UPDOWN cycle of 2nd iteration
    exp_q.delete();
    build_seq(2, 2, 2, 1'b1);
    build_seq(2, 2, 2, 1'b1);
    repeat (4) void'(exp_q.pop_back());
    run("loop222", 8'd2, 8'd2, 8'd2, 1'b1, 1, 0);
    do_abort("loop222_abort");

    // looping with all dwells zero re-enters HOLD
    exp_q.delete();
    build_seq(0, 0, 0, 1'b1);
    build_seq(0, 0, 0, 1'b1);
    exp_q.push_back(4);
    run("loop000", 8'd0, 8'd0, 8'd0, 1'b1, 1, 0);
    do_abort("loop000_abort");

    // start and abort together in IDLE
    @(negedge clk);
    du = 8'd1; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    check_phase("start_abort", 1, 0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;

    // asynchronous reset during DOWN
    exp_q.delete();
    exp_q.push_back(1);
    exp_q.push_back(1);
    exp_q.push_back(2);
    run("pre_rst", 8'd2, 8'd3, 8'd0, 1'b0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check_phase("rst_async", 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_phase("post_rst_idle", i + 1, 0);
    end

    exp_q.delete();
    build_seq(1, 1, 0, 1'b0);
    run("after_rst", 8'd1, 8'd1, 8'd0, 1'b0, 1, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
